// File: rtl/ws2812_tx.sv
// ws2812_tx: shifts GRB pixels out as WS2812 NRZ pulses and latches the chain after each frame
module ws2812_tx #(
  parameter int BIT_CYC = 63,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int RST_CYC = 15000,
  parameter int LED_NUM = 64
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       rgb_valid,
  output logic       rgb_ready,
  output logic       ws_dout,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = $clog2(BIT_CYC + 1);
  localparam int LW = $clog2(RST_CYC + 1);
  localparam int PW = $clog2(LED_NUM + 1);
  localparam logic [1:0] LATCH = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d, thr;
  logic [23:0]   sh_q, sh_d;
  logic          dout_q, dout_d;
  logic          acc, bit_end, pix_end, lat_end, last_pix;

  assign rgb_ready  = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign ws_dout    = dout_q;
  assign acc        = rgb_valid && rgb_ready;
  assign bit_end    = state_q == SEND && cyc_q == CW'(BIT_CYC - 1);
  assign pix_end    = bit_end && bit_q == 5'd23;
  assign lat_end    = state_q == LATCH && lat_q == LW'(RST_CYC - 1);
  assign last_pix   = pix_q == PW'(LED_NUM - 1);
  assign frame_done = lat_end;
  assign thr        = sh_q[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);

  // next-state: pixel accept, bit/pixel sequencing and latch timing
  always_comb begin
    state_d = acc ? SEND : pix_end ? (last_pix ? LATCH : IDLE) : lat_end ? IDLE : state_q;
    lat_d   = (state_q == LATCH && !lat_end) ? lat_q + 1'b1 : '0;
    pix_d   = pix_end ? (last_pix ? '0 : pix_q + 1'b1) : pix_q;
    bit_d   = (acc || pix_end) ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
    cyc_d   = (state_q == SEND && !bit_end) ? cyc_q + 1'b1 : '0;
    sh_d    = acc ? {G, R, B} : bit_end ? {sh_q[22:0], 1'b0} : sh_q;
    dout_d  = state_q == SEND && cyc_q < thr;
  end

  // state registers; reset starts with a full latch so the chain sees a clean frame boundary
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= LATCH;
      lat_q   <= '0;
      pix_q   <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      pix_q   <= pix_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
    end
  end
endmodule
